// File: rtl/multicycle_alu_pkg.sv
// Shared encodings for the ALU/multiply-divide block: ALU function codes,
// multiply/divide opcodes, exception codes and the mult/div FSM states.
package multicycle_alu_pkg;

    typedef enum logic [3:0] {
        F_NULL = 4'b0000,
        F_SUB  = 4'b0001,
        F_OR   = 4'b0010,
        F_SL16 = 4'b0011,
        F_AND  = 4'b0100,
        F_SLT  = 4'b0101,
        F_SLTU = 4'b0110,
        F_ADDI = 4'b0111,
        F_ADD  = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIVS = 2'd2
    } md_state_e;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_ADEL = 4'd4;
    localparam logic [3:0] EXC_ADES = 4'd5;
    localparam logic [3:0] EXC_OV   = 4'd12;

    localparam int CNT_W = 5;

endpackage

// File: rtl/multicycle_alu_mdu.sv
// Sequential multiply/divide unit: FSM, latency counter, operand latches and HI/LO.
// Results are formed from the latched operands and written on the edge busy falls.
module mdu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_md_op,
    input  logic             i_start,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output md_state_e        o_state
);

    md_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic               r_signed, w_signed_nxt;
    logic [WIDTH-1:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;

    logic               w_accept;
    logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_den;
    logic [WIDTH-1:0]   w_q_mag, w_r_mag, w_quot, w_rem;

    assign w_accept = i_start && !i_cancel && (r_state == MD_IDLE)
                      && (i_md_op != MD_NONE);

    // Sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both forms.
    assign w_a_ext = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide on magnitudes, then fix signs: quotient truncates toward zero and
    // the remainder follows the dividend. Most-negative / -1 falls out as
    // most-negative with remainder 0 because its magnitude wraps to itself.
    assign w_a_neg = r_signed && r_a[WIDTH-1];
    assign w_b_neg = r_signed && r_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -r_a : r_a;
    assign w_b_mag = w_b_neg ? -r_b : r_b;
    assign w_den   = (w_b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag = w_a_mag / w_den;
    assign w_r_mag = w_a_mag % w_den;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_signed_nxt = r_signed;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        case (r_state)
            MD_IDLE: begin
                if (w_accept) begin
                    case (i_md_op)
                        MD_MULT, MD_MULTU: begin
                            w_state_nxt  = MD_MUL;
                            w_cnt_nxt    = CNT_W'(MUL_LAT);
                            w_a_nxt      = i_a;
                            w_b_nxt      = i_b;
                            w_signed_nxt = (i_md_op == MD_MULT);
                        end
                        MD_DIV, MD_DIVU: begin
                            w_state_nxt  = MD_DIVS;
                            w_cnt_nxt    = CNT_W'(DIV_LAT);
                            w_a_nxt      = i_a;
                            w_b_nxt      = i_b;
                            w_signed_nxt = (i_md_op == MD_DIV);
                        end
                        MD_MTHI: w_hi_nxt = i_a;
                        MD_MTLO: w_lo_nxt = i_a;
                        default: ;
                    endcase
                end
            end
            MD_MUL: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = MD_IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_nxt    = w_prod[WIDTH-1:0];
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            MD_DIVS: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = MD_IDLE;
                    w_cnt_nxt   = '0;
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (r_b != '0) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quot;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_signed <= w_signed_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign o_busy  = (r_state != MD_IDLE);
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_state = r_state;

endmodule

// File: rtl/multicycle_alu.sv
// Combinational ALU with overflow/address exceptions, alongside the sequential
// multiply/divide unit that owns HI/LO.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       F,
    input  logic [2:0]       load_type,
    input  logic [2:0]       store_type,
    input  logic [2:0]       md_op,
    input  logic             start,
    input  logic             cancel,
    output logic [WIDTH-1:0] C,
    output logic [3:0]       exc,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_e        dbg_md_state
);

    logic [WIDTH:0]   w_sum, w_diff;
    logic             w_add_ovf, w_sub_ovf, w_is_add;
    logic [WIDTH-1:0] w_c;
    logic [3:0]       w_exc;

    // Overflow is the disagreement of the top two bits of the sign-extended result.
    assign w_sum     = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    assign w_diff    = {A[WIDTH-1], A} - {B[WIDTH-1], B};
    assign w_add_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_sub_ovf = w_diff[WIDTH] ^ w_diff[WIDTH-1];
    assign w_is_add  = (F == F_ADD);

    always_comb begin
        w_c = '0;
        case (F)
            F_ADD, F_ADDI: w_c = w_sum[WIDTH-1:0];
            F_SUB:         w_c = w_diff[WIDTH-1:0];
            F_OR:          w_c = A | B;
            F_AND:         w_c = A & B;
            F_SL16:        w_c = B << 16;
            F_SLT:         w_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            F_SLTU:        w_c = {{(WIDTH-1){1'b0}}, (A < B)};
            default:       w_c = '0;
        endcase
    end

    // Only a plain ADD can be an address computation; ADDI/SUB overflow is arithmetic.
    always_comb begin
        w_exc = EXC_NONE;
        if (w_is_add && w_add_ovf && (load_type != 3'd0)) begin
            w_exc = EXC_ADEL;
        end else if (w_is_add && w_add_ovf && (store_type != 3'd0)) begin
            w_exc = EXC_ADES;
        end else if (((w_is_add || (F == F_ADDI)) && w_add_ovf)
                     || ((F == F_SUB) && w_sub_ovf)) begin
            w_exc = EXC_OV;
        end
    end

    assign C   = w_c;
    assign exc = w_exc;

    mdu #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_a      (A),
        .i_b      (B),
        .i_md_op  (md_op),
        .i_start  (start),
        .i_cancel (cancel),
        .o_busy   (busy),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_state  (dbg_md_state)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a vector table for the combinational ALU
// plus hand-written sequences for multiply/divide timing and corner cases.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  A = '0, B = '0;
    logic [3:0]    F = 4'd0;
    logic [2:0]    load_type = 3'd0, store_type = 3'd0;
    logic [2:0]    md_op = 3'd0;
    logic          start = 1'b0, cancel = 1'b0;
    logic [W-1:0]  C, hi, lo;
    logic [3:0]    exc;
    logic          busy;
    md_state_e     dbg_md_state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_alu #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .F            (F),
        .load_type    (load_type),
        .store_type   (store_type),
        .md_op        (md_op),
        .start        (start),
        .cancel       (cancel),
        .C            (C),
        .exc          (exc),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo),
        .dbg_md_state (dbg_md_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   ld;
        logic [2:0]   st;
        logic [W-1:0] c;
        logic [3:0]   exc;
    } alu_vec_t;

    alu_vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        A = a;
        B = b;
        md_op = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_md(input string name, input int n_exp, input logic [W-1:0] hi_exp,
                            input logic [W-1:0] lo_exp);
        int n;
        wait_idle(n);
        check({name, ".busy_cycles"}, 64'(n), 64'(n_exp));
        check({name, ".hi"}, 64'(hi), 64'(hi_exp));
        check({name, ".lo"}, 64'(lo), 64'(lo_exp));
    endtask

    initial begin
        vecs[0]  = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 3'd1, 3'd0, 32'h80000000, 4'd4};
        vecs[1]  = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 3'd0, 3'd2, 32'h80000000, 4'd5};
        vecs[2]  = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 3'd0, 3'd0, 32'h80000000, 4'd12};
        vecs[3]  = '{F_ADDI, 32'h7FFFFFFF, 32'h00000001, 3'd1, 3'd0, 32'h80000000, 4'd12};
        vecs[4]  = '{F_ADD,  32'h00000005, 32'h00000003, 3'd1, 3'd0, 32'h00000008, 4'd0};
        vecs[5]  = '{F_SUB,  32'h80000000, 32'h00000001, 3'd1, 3'd0, 32'h7FFFFFFF, 4'd12};
        vecs[6]  = '{F_SUB,  32'h00000005, 32'h00000007, 3'd0, 3'd0, 32'hFFFFFFFE, 4'd0};
        vecs[7]  = '{F_OR,   32'h0000F0F0, 32'h00000F0F, 3'd0, 3'd0, 32'h0000FFFF, 4'd0};
        vecs[8]  = '{F_AND,  32'hFF00FF00, 32'h0FF00FF0, 3'd0, 3'd0, 32'h0F000F00, 4'd0};
        vecs[9]  = '{F_SL16, 32'h12345678, 32'h0000ABCD, 3'd0, 3'd0, 32'hABCD0000, 4'd0};
        vecs[10] = '{F_SLT,  32'hFFFFFFFF, 32'h00000001, 3'd0, 3'd0, 32'h00000001, 4'd0};
        vecs[11] = '{F_SLTU, 32'hFFFFFFFF, 32'h00000001, 3'd0, 3'd0, 32'h00000000, 4'd0};
        vecs[12] = '{F_NULL, 32'h00000001, 32'h00000002, 3'd0, 3'd0, 32'h00000000, 4'd0};
        vecs[13] = '{4'b1000, 32'h00000001, 32'h00000002, 3'd0, 3'd0, 32'h00000000, 4'd0};
        vecs[14] = '{F_ADD,  32'h80000000, 32'h80000000, 3'd0, 3'd1, 32'h00000000, 4'd5};
        vecs[15] = '{F_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 3'd0, 3'd0, 32'h80000000, 4'd12};

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.hi", 64'(hi), 64'(0));
        check("reset.lo", 64'(lo), 64'(0));
        check("reset.state", 64'(dbg_md_state), 64'(MD_IDLE));

        // Combinational ALU table
        for (int i = 0; i < 16; i++) begin
            F = vecs[i].f;
            A = vecs[i].a;
            B = vecs[i].b;
            load_type = vecs[i].ld;
            store_type = vecs[i].st;
            #1;
            check($sformatf("alu[%0d].c", i), 64'(C), 64'(vecs[i].c));
            check($sformatf("alu[%0d].exc", i), 64'(exc), 64'(vecs[i].exc));
        end
        load_type = 3'd0;
        store_type = 3'd0;
        @(negedge clk);

        // MULT with operands changed while busy; ALU keeps working meanwhile
        issue(MD_MULT, 32'hFFFFFFFF, 32'h00000002);
        check("mult.state", 64'(dbg_md_state), 64'(MD_MUL));
        F = F_ADD;
        A = 32'd2;
        B = 32'd3;
        #1;
        check("alu_while_busy.c", 64'(C), 64'(5));
        check_md("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'h00000002);
        check_md("multu", 5, 32'h00000001, 32'hFFFFFFFE);

        // Divides
        issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
        check_md("div_neg", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(MD_DIVU, 32'hFFFFFFF9, 32'h00000002);
        check_md("divu", 10, 32'h00000001, 32'h7FFFFFFC);
        issue(MD_DIV, 32'h00001234, 32'h00000000);
        check_md("div_zero", 10, 32'h00000001, 32'h7FFFFFFC);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        check_md("div_minneg", 10, 32'h00000000, 32'h80000000);
        issue(MD_DIV, 32'h00000007, 32'hFFFFFFFE);
        check_md("div_pos_neg", 10, 32'h00000001, 32'hFFFFFFFD);

        // Starts while a divide is running: busy cycle 3 and busy cycle 10
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        A = 32'd3;
        B = 32'd4;
        md_op = MD_MULT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check("overlap.c3_busy", 64'(busy), 64'(1));
        repeat (6) @(negedge clk);
        check("overlap.c10_busy", 64'(busy), 64'(1));
        md_op = MD_MULT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check("overlap.c11_busy", 64'(busy), 64'(0));
        check("overlap.hi", 64'(hi), 64'(2));
        check("overlap.lo", 64'(lo), 64'(14));
        issue(MD_MULT, 32'd3, 32'd4);
        check_md("overlap.mult", 5, 32'h0, 32'd12);

        // Reset aborts a running multiply
        issue(MD_MULT, 32'd5, 32'd6);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.hi", 64'(hi), 64'(0));
        check("abort.lo", 64'(lo), 64'(0));
        repeat (8) @(negedge clk);
        check("abort.lo_later", 64'(lo), 64'(0));

        // Reset wins over a same-cycle start
        issue(MD_MTLO, 32'h0000AAAA, 32'h0);
        check("mtlo.lo", 64'(lo), 64'(32'h0000AAAA));
        reset = 1'b1;
        issue(MD_MTLO, 32'h00005555, 32'h0);
        reset = 1'b0;
        check("reset_prio.lo", 64'(lo), 64'(0));

        // Cancel kills MTHI and MULT; uncancelled MTHI writes without busy
        cancel = 1'b1;
        issue(MD_MTHI, 32'h12345678, 32'h0);
        check("cancel_mthi.hi", 64'(hi), 64'(0));
        issue(MD_MULT, 32'd9, 32'd9);
        check("cancel_mult.busy", 64'(busy), 64'(0));
        cancel = 1'b0;
        issue(MD_MTHI, 32'h12345678, 32'h0);
        check("mthi.hi", 64'(hi), 64'(32'h12345678));
        check("mthi.busy", 64'(busy), 64'(0));
        check("mthi.lo", 64'(lo), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
